gen_fifo_wptr_full: RTL and testbench

//   Write-side pointer and full-flag logic for an asynchronous FIFO. Keeps the binary write

---
 rtl/gen_fifo_wptr_full_if.sv | 39 +++
 rtl/gen_fifo_wptr_full.sv | 95 +++++++++
 tb/tb_gen_fifo_wptr_full.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_fifo_wptr_full_if.sv
// Write-side bus of the async FIFO write-pointer block: producer handshake,
// read-domain gray pointer in, and the write strobe/address/pointer/status out.
interface gen_fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_req;
  logic [ADDR_WIDTH:0]   rd_gptr_async;
  logic                  ovf_clr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic                  ovf_err;

  modport master (
    output wr_req,
    output rd_gptr_async,
    output ovf_clr,
    input  wr_en,
    input  waddr,
    input  wptr_gray,
    input  full,
    input  almost_full,
    input  ovf_err
  );

  modport slave (
    input  wr_req,
    input  rd_gptr_async,
    input  ovf_clr,
    output wr_en,
    output waddr,
    output wptr_gray,
    output full,
    output almost_full,
    output ovf_err
  );
endinterface

// File: rtl/gen_fifo_wptr_full.sv
// Async FIFO write side: binary/gray write pointer, read-pointer synchroniser,
// registered full / almost-full, and sticky overflow flag.
module gen_fifo_wptr_full #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gen_fifo_wptr_full_if.slave   bus
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AF_T = (AW+1)'(AF_THRESH);

  logic [AW:0] r_wbin;
  logic [AW:0] r_wgray;
  logic [AW:0] r_sync [SYNC_STAGES];
  logic        r_full;
  logic        r_af;
  logic        r_ovf;

  logic        w_wr_en;
  logic [AW:0] w_wbin_nxt;
  logic [AW:0] w_gray_nxt;
  logic [AW:0] w_rq_gray;
  logic [AW:0] w_rq_bin;
  logic [AW:0] w_level_nxt;
  logic        w_full_nxt;
  logic        w_af_nxt;

  // rst_n gates the strobe so no RAM write can slip through while reset is held.
  assign w_wr_en    = bus.wr_req & ~r_full & rst_n;
  assign w_wbin_nxt = r_wbin + {{AW{1'b0}}, w_wr_en};
  assign w_gray_nxt = w_wbin_nxt ^ (w_wbin_nxt >> 1);

  assign w_rq_gray  = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_rq_bin     = '0;
    w_rq_bin[AW] = w_rq_gray[AW];
    for (int unsigned i = 0; i < AW; i++) begin
      w_rq_bin[AW-1-i] = w_rq_bin[AW-i] ^ w_rq_gray[AW-1-i];
    end
  end

  // Full when the write pointer has lapped the read pointer by exactly one depth.
  assign w_full_nxt  = (w_gray_nxt == {~w_rq_gray[AW:AW-1], w_rq_gray[AW-2:0]});
  assign w_level_nxt = w_wbin_nxt - w_rq_bin;
  assign w_af_nxt    = (w_level_nxt >= AF_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= bus.rd_gptr_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_nxt;
      r_wgray <= w_gray_nxt;
      r_full  <= w_full_nxt;
      r_af    <= w_af_nxt;
    end
  end

  // Set has priority over clear so a same-cycle overflow is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.wr_req && r_full) begin
      r_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.wr_en       = w_wr_en;
  assign bus.waddr       = r_wbin[AW-1:0];
  assign bus.wptr_gray   = r_wgray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_af;
  assign bus.ovf_err     = r_ovf;
endmodule

// File: tb/tb_gen_fifo_wptr_full.sv
// Self-checking bench for gen_fifo_wptr_full: table-driven fill/overflow, directed
// drain/wrap/reset sequences, and randomized traffic against an occupancy model.
module tb_gen_fifo_wptr_full;
  localparam int AW    = 4;
  localparam int SYNC  = 2;
  localparam int AFT   = 12;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic clk = 1'b0;
  logic rst_n;

  gen_fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus();

  gen_fifo_wptr_full #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SYNC),
    .AF_THRESH  (AFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: write count, read count seen through the synchroniser delay.
  int m_w;
  bit m_full, m_af, m_ovf, m_we;
  int m_hist [SYNC];
  int tot_w, tot_r;

  typedef struct {
    bit         wr;
    bit         clr;
    bit         exp_wren;
    logic [3:0] exp_waddr;
    logic [4:0] exp_gray;
    bit         exp_full;
    bit         exp_af;
    bit         exp_ovf;
  } vec_t;
  vec_t tbl [21];

  function automatic logic [AW:0] gray(int b);
    logic [AW:0] v;
    v = (AW+1)'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_full = 0; m_af = 0; m_ovf = 0; m_we = 0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    tot_w = 0; tot_r = 0;
  endtask

  task automatic model_edge(bit wr, int rdb, bit clr);
    int wn, lvl;
    m_we  = wr && !m_full;
    wn    = (m_w + (m_we ? 1 : 0)) % PMOD;
    lvl   = (wn - m_hist[SYNC-1] + PMOD) % PMOD;
    m_ovf = (wr && m_full) || (m_ovf && !clr);
    m_full = (lvl == DEPTH);
    m_af   = (lvl >= AFT);
    m_w    = wn;
    for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = rdb % PMOD;
    if (m_we) tot_w++;
  endtask

  task automatic step(bit wr, int rdb, bit clr);
    @(negedge clk);
    bus.wr_req        = wr;
    bus.rd_gptr_async = gray(rdb);
    bus.ovf_clr       = clr;
    #1;
    chk("wr_en",       bus.wr_en,       32'(wr && !m_full));
    chk("waddr",       bus.waddr,       32'(m_w % DEPTH));
    chk("wptr_gray",   bus.wptr_gray,   32'(gray(m_w)));
    chk("full",        bus.full,        32'(m_full));
    chk("almost_full", bus.almost_full, 32'(m_af));
    chk("ovf_err",     bus.ovf_err,     32'(m_ovf));
    model_edge(wr, rdb, clr);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_waddr"}, bus.waddr, 0);
    chk({tag, "_gray"},  bus.wptr_gray, 0);
    chk({tag, "_full"},  bus.full, 0);
    chk({tag, "_af"},    bus.almost_full, 0);
    chk({tag, "_ovf"},   bus.ovf_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.wr_req = 1'b0; bus.ovf_clr = 1'b0; bus.rd_gptr_async = '0;
    @(negedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    model_reset();
    model_edge(0, 0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW:0] pg;
    bit pwrote;
    int pprev_w, wb, pw, pr;
    bit wr, clr;

    for (int k = 0; k < 18; k++) begin
      int n;
      n = (k < DEPTH) ? k : DEPTH;
      tbl[k] = '{wr: 1, clr: 0, exp_wren: (k < DEPTH), exp_waddr: 4'(n % DEPTH),
                 exp_gray: gray(n), exp_full: (k >= DEPTH), exp_af: (n >= AFT),
                 exp_ovf: (k >= DEPTH + 1)};
    end
    tbl[18] = '{wr: 1, clr: 1, exp_wren: 0, exp_waddr: 4'd0, exp_gray: 5'b11000,
                exp_full: 1, exp_af: 1, exp_ovf: 1};
    tbl[19] = '{wr: 0, clr: 1, exp_wren: 0, exp_waddr: 4'd0, exp_gray: 5'b11000,
                exp_full: 1, exp_af: 1, exp_ovf: 1};
    tbl[20] = '{wr: 0, clr: 0, exp_wren: 0, exp_waddr: 4'd0, exp_gray: 5'b11000,
                exp_full: 1, exp_af: 1, exp_ovf: 0};

    // Reset held with activity on the inputs.
    rst_n = 1'b0;
    bus.wr_req = 1'b1; bus.ovf_clr = 1'b0; bus.rd_gptr_async = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.rd_gptr_async = 5'($urandom);
      #1;
      chk_zero("hold_rst");
    end
    @(negedge clk);
    bus.wr_req = 1'b0; bus.rd_gptr_async = '0;
    rst_n = 1'b1;
    model_reset();
    model_edge(0, 0, 0);
    step(1, 0, 0);
    chk("first_waddr0", bus.waddr, 0);
    chk("first_gray0",  bus.wptr_gray, 0);
    step(0, 0, 0);
    chk("first_waddr1", bus.waddr, 1);
    chk("first_gray1",  bus.wptr_gray, 5'b00001);

    // Fill, overflow, set-wins clear, clear.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].wr, 0, tbl[i].clr);
      chk("tbl_wr_en", bus.wr_en,       32'(tbl[i].exp_wren));
      chk("tbl_waddr", bus.waddr,       32'(tbl[i].exp_waddr));
      chk("tbl_gray",  bus.wptr_gray,   32'(tbl[i].exp_gray));
      chk("tbl_full",  bus.full,        32'(tbl[i].exp_full));
      chk("tbl_af",    bus.almost_full, 32'(tbl[i].exp_af));
      chk("tbl_ovf",   bus.ovf_err,     32'(tbl[i].exp_ovf));
    end

    // Drain: full clears 3 edges after the read pointer moves to 4; af holds at level 12.
    for (int j = 0; j < 5; j++) begin
      step(0, 4, 0);
      chk("drain_full", bus.full, 32'(j < 3));
      chk("drain_af4",  bus.almost_full, 1);
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 5, 0);
      chk("drain_af5", bus.almost_full, 32'(j < 3));
    end

    // Wrap with the read pointer trailing by 3.
    do_reset();
    pg = '0; pwrote = 0; pprev_w = 0;
    for (int i = 0; i < 71; i++) begin
      wb = m_w;
      step(1, (tot_w >= 3) ? tot_w - 3 : 0, 0);
      if (pwrote) begin
        chk("gray_1bit", $countones(bus.wptr_gray ^ pg), 1);
        if (pprev_w == PMOD - 1) begin
          chk("wrap_from", 32'(pg), 32'(5'b10000));
          chk("wrap_to",   bus.wptr_gray, 0);
        end
      end
      chk("wrap_nofull", bus.full, 0);
      pg = bus.wptr_gray;
      pwrote = m_we;
      pprev_w = wb;
    end

    // Short asynchronous reset pulse mid-operation.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.ovf_clr = 1'b0;
    #1;
    chk("pre_pulse_waddr", bus.waddr, 9);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("pulse");
    bus.wr_req = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    model_edge(0, 0, 0);
    step(1, 0, 0);
    chk("restart_waddr0", bus.waddr, 0);
    step(1, 0, 0);
    chk("restart_waddr1", bus.waddr, 1);

    // Randomized traffic: producer-heavy, then consumer-heavy.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pw = (i < 1500) ? 80 : 30;
      pr = (i < 1500) ? 30 : 80;
      wr  = ($urandom_range(0, 99) < pw);
      clr = ($urandom_range(0, 9) == 0);
      if (tot_r < tot_w && $urandom_range(0, 99) < pr) tot_r++;
      step(wr, tot_r, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
